// File: rtl/reset_seq_pkg.sv
// Shared types, default parameters and sizing helper for the staged reset sequencer.
package reset_seq_pkg;

  // Sequencer states: stretch reset, filter PLL lock, release stages in order, steady run.
  typedef enum logic [1:0] {
    ST_ASSERT    = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_RELEASE   = 2'd2,
    ST_RUN       = 2'd3
  } reset_seq_state_t;

  localparam int DEF_NUM_STAGES  = 3;
  localparam int DEF_HOLD_CYCLES = 16;
  localparam int DEF_LOCK_FILTER = 4;
  localparam int DEF_STAGE_GAP   = 8;

  // Width of one counter able to hold the largest of the three thresholds.
  function automatic int cnt_width(input int hold, input int lock, input int gap);
    int max_v;
    max_v = (hold > lock) ? hold : lock;
    max_v = (gap > max_v) ? gap : max_v;
    return $clog2(max_v + 1);
  endfunction

endpackage

// File: rtl/reset_sequencer.sv
// Staged reset release controller: stretches reset, filters PLL lock, then releases
// NUM_STAGES active-low resets one at a time; any abort drops every stage at once.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_STAGES  = DEF_NUM_STAGES,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int LOCK_FILTER = DEF_LOCK_FILTER,
  parameter int STAGE_GAP   = DEF_STAGE_GAP
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  pll_locked_i,
  input  logic                  sw_rst_req_i,
  output logic [NUM_STAGES-1:0] stage_rst_n_o,
  output logic                  all_released_o,
  output logic                  busy_o
);

  localparam int CNT_W = cnt_width(HOLD_CYCLES, LOCK_FILTER, STAGE_GAP);
  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  // Counters stop one short of each threshold: the threshold edge itself moves on.
  localparam logic [CNT_W-1:0]      CNT_ZERO   = CNT_W'(0);
  localparam logic [CNT_W-1:0]      CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]      HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]      LOCK_LAST  = CNT_W'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0]      GAP_LAST   = CNT_W'(STAGE_GAP - 1);
  localparam logic [IDX_W-1:0]      IDX_ZERO   = IDX_W'(0);
  localparam logic [IDX_W-1:0]      IDX_ONE    = IDX_W'(1);
  localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_STAGES - 1);
  localparam logic [NUM_STAGES-1:0] STAGE_NONE = NUM_STAGES'(0);
  localparam logic [NUM_STAGES-1:0] STAGE_ONE  = NUM_STAGES'(1);

  reset_seq_state_t        state_r, state_s;
  logic [CNT_W-1:0]        hold_cnt_r, hold_cnt_s;
  logic [CNT_W-1:0]        lock_cnt_r, lock_cnt_s;
  logic [CNT_W-1:0]        gap_cnt_r, gap_cnt_s;
  logic [IDX_W-1:0]        stage_idx_r, stage_idx_s;
  logic [NUM_STAGES-1:0]   stage_rst_n_r, stage_rst_n_s;
  logic                    all_released_r, all_released_s;
  logic                    busy_r, busy_s;
  logic                    abort_s;

  // State, counters and outputs all register here; async clear forces full reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r        <= ST_ASSERT;
      hold_cnt_r     <= CNT_ZERO;
      lock_cnt_r     <= CNT_ZERO;
      gap_cnt_r      <= CNT_ZERO;
      stage_idx_r    <= IDX_ZERO;
      stage_rst_n_r  <= STAGE_NONE;
      all_released_r <= 1'b0;
      busy_r         <= 1'b1;
    end else begin
      state_r        <= state_s;
      hold_cnt_r     <= hold_cnt_s;
      lock_cnt_r     <= lock_cnt_s;
      gap_cnt_r      <= gap_cnt_s;
      stage_idx_r    <= stage_idx_s;
      stage_rst_n_r  <= stage_rst_n_s;
      all_released_r <= all_released_s;
      busy_r         <= busy_s;
    end
  end

  // Next-state, counter and output logic; lock loss in WAIT_LOCK only resets the filter.
  always_comb begin
    state_s        = state_r;
    hold_cnt_s     = hold_cnt_r;
    lock_cnt_s     = lock_cnt_r;
    gap_cnt_s      = gap_cnt_r;
    stage_idx_s    = stage_idx_r;
    stage_rst_n_s  = stage_rst_n_r;
    all_released_s = all_released_r;
    busy_s         = busy_r;
    abort_s        = 1'b0;

    case (state_r)
      ST_WAIT_LOCK: abort_s = sw_rst_req_i;
      ST_RELEASE:   abort_s = ~pll_locked_i | sw_rst_req_i;
      ST_RUN:       abort_s = ~pll_locked_i | sw_rst_req_i;
      default:      abort_s = 1'b0;
    endcase

    if (abort_s) begin
      state_s        = ST_ASSERT;
      hold_cnt_s     = CNT_ZERO;
      lock_cnt_s     = CNT_ZERO;
      gap_cnt_s      = CNT_ZERO;
      stage_idx_s    = IDX_ZERO;
      stage_rst_n_s  = STAGE_NONE;
      all_released_s = 1'b0;
      busy_s         = 1'b1;
    end else begin
      case (state_r)
        ST_ASSERT: begin
          if (sw_rst_req_i) begin
            hold_cnt_s = CNT_ZERO;
          end else if (hold_cnt_r == HOLD_LAST) begin
            hold_cnt_s = CNT_ZERO;
            lock_cnt_s = CNT_ZERO;
            state_s    = ST_WAIT_LOCK;
          end else begin
            hold_cnt_s = hold_cnt_r + CNT_ONE;
          end
        end
        ST_WAIT_LOCK: begin
          if (!pll_locked_i) begin
            lock_cnt_s = CNT_ZERO;
          end else if (lock_cnt_r == LOCK_LAST) begin
            lock_cnt_s    = CNT_ZERO;
            gap_cnt_s     = CNT_ZERO;
            stage_rst_n_s = stage_rst_n_r | STAGE_ONE;
            if (NUM_STAGES == 1) begin
              state_s        = ST_RUN;
              all_released_s = 1'b1;
              busy_s         = 1'b0;
            end else begin
              state_s     = ST_RELEASE;
              stage_idx_s = IDX_ONE;
            end
          end else begin
            lock_cnt_s = lock_cnt_r + CNT_ONE;
          end
        end
        ST_RELEASE: begin
          if (gap_cnt_r == GAP_LAST) begin
            gap_cnt_s     = CNT_ZERO;
            stage_rst_n_s = stage_rst_n_r | (STAGE_ONE << stage_idx_r);
            if (stage_idx_r == IDX_LAST) begin
              state_s        = ST_RUN;
              all_released_s = 1'b1;
              busy_s         = 1'b0;
            end else begin
              stage_idx_s = stage_idx_r + IDX_ONE;
            end
          end else begin
            gap_cnt_s = gap_cnt_r + CNT_ONE;
          end
        end
        ST_RUN: begin
          state_s = ST_RUN;
        end
        default: begin
          state_s        = ST_ASSERT;
          hold_cnt_s     = CNT_ZERO;
          lock_cnt_s     = CNT_ZERO;
          gap_cnt_s      = CNT_ZERO;
          stage_idx_s    = IDX_ZERO;
          stage_rst_n_s  = STAGE_NONE;
          all_released_s = 1'b0;
          busy_s         = 1'b1;
        end
      endcase
    end
  end

  assign stage_rst_n_o  = stage_rst_n_r;
  assign all_released_o = all_released_r;
  assign busy_o         = busy_r;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed self-checking bench for reset_sequencer (default build plus a 1-stage build).
module tb_reset_sequencer;

  logic       clk;
  logic       rst_n;
  logic       pll_locked;
  logic       sw_rst_req;
  logic [2:0] stage_rst_n;
  logic       all_released;
  logic       busy;

  logic       rst1_n;
  logic       lock1;
  logic       sw1;
  logic [0:0] stage1;
  logic       all1;
  logic       busy1;

  int checks;
  int failures;

  reset_sequencer u_dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .pll_locked_i  (pll_locked),
    .sw_rst_req_i  (sw_rst_req),
    .stage_rst_n_o (stage_rst_n),
    .all_released_o(all_released),
    .busy_o        (busy)
  );

  reset_sequencer #(
    .NUM_STAGES (1),
    .HOLD_CYCLES(1),
    .LOCK_FILTER(1)
  ) u_one (
    .clk_i         (clk),
    .rst_n_i       (rst1_n),
    .pll_locked_i  (lock1),
    .sw_rst_req_i  (sw1),
    .stage_rst_n_o (stage1),
    .all_released_o(all1),
    .busy_o        (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pll_locked = 1'b1; sw_rst_req = 1'b0;
    repeat (3) tick();
    checks++; if (stage_rst_n !== 3'b000) begin failures++; $display("FAIL reset_stage got=%b exp=%b", stage_rst_n, 3'b000); end
    checks++; if (all_released !== 1'b0) begin failures++; $display("FAIL reset_all got=%b exp=0", all_released); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL reset_busy got=%b exp=1", busy); end
  endtask

  task automatic test_nominal();
    logic [2:0] exp_stage;
    logic       exp_all;
    pll_locked = 1'b1;
    rst_n = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      tick();
      exp_stage = (e >= 36) ? 3'b111 : (e >= 28) ? 3'b011 : (e >= 20) ? 3'b001 : 3'b000;
      exp_all   = (e >= 36);
      checks++; if (stage_rst_n !== exp_stage) begin failures++; $display("FAIL nominal_stage edge=%0d got=%b exp=%b", e, stage_rst_n, exp_stage); end
      checks++; if (all_released !== exp_all) begin failures++; $display("FAIL nominal_all edge=%0d got=%b exp=%b", e, all_released, exp_all); end
      checks++; if (busy !== ~exp_all) begin failures++; $display("FAIL nominal_busy edge=%0d got=%b exp=%b", e, busy, ~exp_all); end
    end
  endtask

  task automatic test_lock_filter();
    hold_reset();
    for (int e = 1; e <= 31; e++) begin
      pll_locked = (e >= 17) && (e != 19);
      tick();
      if (e == 22) begin
        checks++; if (stage_rst_n !== 3'b000) begin failures++; $display("FAIL filter_pre edge=%0d got=%b exp=%b", e, stage_rst_n, 3'b000); end
      end
      if (e == 23) begin
        checks++; if (stage_rst_n !== 3'b001) begin failures++; $display("FAIL filter_rel edge=%0d got=%b exp=%b", e, stage_rst_n, 3'b001); end
      end
      if (e == 31) begin
        checks++; if (stage_rst_n !== 3'b011) begin failures++; $display("FAIL filter_stage1 edge=%0d got=%b exp=%b", e, stage_rst_n, 3'b011); end
      end
    end
  endtask

  task automatic test_lock_loss();
    pll_locked = 1'b1;
    hold_reset();
    for (int e = 1; e <= 66; e++) begin
      pll_locked = (e != 30);
      tick();
      if (e == 29) begin
        checks++; if (stage_rst_n !== 3'b011) begin failures++; $display("FAIL loss_before got=%b exp=%b", stage_rst_n, 3'b011); end
      end
      if (e == 30) begin
        checks++; if (stage_rst_n !== 3'b000) begin failures++; $display("FAIL loss_stage got=%b exp=%b", stage_rst_n, 3'b000); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL loss_busy got=%b exp=1", busy); end
        checks++; if (all_released !== 1'b0) begin failures++; $display("FAIL loss_all got=%b exp=0", all_released); end
      end
      if (e == 49) begin
        checks++; if (stage_rst_n !== 3'b000) begin failures++; $display("FAIL loss_replay_pre got=%b exp=%b", stage_rst_n, 3'b000); end
      end
      if (e == 50) begin
        checks++; if (stage_rst_n !== 3'b001) begin failures++; $display("FAIL loss_replay_s0 got=%b exp=%b", stage_rst_n, 3'b001); end
      end
      if (e == 66) begin
        checks++; if (stage_rst_n !== 3'b111) begin failures++; $display("FAIL loss_replay_all got=%b exp=%b", stage_rst_n, 3'b111); end
        checks++; if (all_released !== 1'b1) begin failures++; $display("FAIL loss_replay_rel got=%b exp=1", all_released); end
      end
    end
  endtask

  task automatic test_sw_request();
    pll_locked = 1'b1;
    for (int e = 1; e <= 25; e++) begin
      sw_rst_req = (e == 1) || (e == 5);
      tick();
      sw_rst_req = 1'b0;
      if (e == 1) begin
        checks++; if (stage_rst_n !== 3'b000) begin failures++; $display("FAIL sw_abort_stage got=%b exp=%b", stage_rst_n, 3'b000); end
        checks++; if (all_released !== 1'b0) begin failures++; $display("FAIL sw_abort_all got=%b exp=0", all_released); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL sw_abort_busy got=%b exp=1", busy); end
      end
      if (e == 21 || e == 24) begin
        checks++; if (stage_rst_n !== 3'b000) begin failures++; $display("FAIL sw_extend_hold edge=%0d got=%b exp=%b", e, stage_rst_n, 3'b000); end
      end
      if (e == 25) begin
        checks++; if (stage_rst_n !== 3'b001) begin failures++; $display("FAIL sw_extend_rel got=%b exp=%b", stage_rst_n, 3'b001); end
      end
    end
  endtask

  task automatic test_async_reset();
    pll_locked = 1'b1;
    hold_reset();
    repeat (30) tick();
    checks++; if (stage_rst_n !== 3'b011) begin failures++; $display("FAIL async_pre got=%b exp=%b", stage_rst_n, 3'b011); end
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (stage_rst_n !== 3'b000) begin failures++; $display("FAIL async_stage got=%b exp=%b", stage_rst_n, 3'b000); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL async_busy got=%b exp=1", busy); end
    checks++; if (all_released !== 1'b0) begin failures++; $display("FAIL async_all got=%b exp=0", all_released); end
    tick();
    tick();
    rst_n = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (e == 19) begin
        checks++; if (stage_rst_n !== 3'b000) begin failures++; $display("FAIL async_replay_pre got=%b exp=%b", stage_rst_n, 3'b000); end
      end
      if (e == 20) begin
        checks++; if (stage_rst_n !== 3'b001) begin failures++; $display("FAIL async_replay_s0 got=%b exp=%b", stage_rst_n, 3'b001); end
      end
    end
  endtask

  task automatic test_single_stage();
    checks++; if (stage1 !== 1'b0) begin failures++; $display("FAIL single_reset_stage got=%b exp=0", stage1); end
    checks++; if (busy1 !== 1'b1) begin failures++; $display("FAIL single_reset_busy got=%b exp=1", busy1); end
    rst1_n = 1'b1;
    tick();
    checks++; if (stage1 !== 1'b0) begin failures++; $display("FAIL single_e1_stage got=%b exp=0", stage1); end
    checks++; if (all1 !== 1'b0) begin failures++; $display("FAIL single_e1_all got=%b exp=0", all1); end
    tick();
    checks++; if (stage1 !== 1'b1) begin failures++; $display("FAIL single_e2_stage got=%b exp=1", stage1); end
    checks++; if (all1 !== 1'b1) begin failures++; $display("FAIL single_e2_all got=%b exp=1", all1); end
    checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL single_e2_busy got=%b exp=0", busy1); end
    lock1 = 1'b0;
    tick();
    checks++; if (stage1 !== 1'b0) begin failures++; $display("FAIL single_abort_stage got=%b exp=0", stage1); end
    checks++; if (all1 !== 1'b0) begin failures++; $display("FAIL single_abort_all got=%b exp=0", all1); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0; pll_locked = 1'b1; sw_rst_req = 1'b0;
    rst1_n = 1'b0; lock1 = 1'b1; sw1 = 1'b0;
    test_reset();
    test_nominal();
    test_lock_filter();
    test_lock_loss();
    test_sw_request();
    test_async_reset();
    test_single_stage();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Staged reset release controller sitting directly downstream of `reset_sync`. It consumes the synchronized active-low reset, holds all downstream domains in reset for a minimum stretch, and waits for a filtered PLL lock. It then releases `NUM_STAGES` reset outputs one at a time, in index order, with a fixed gap between releases. Any lock loss or software reset request re-asserts all stages and restarts the sequence.

## Interface
Parameters:
- `NUM_STAGES`, 3: number of sequenced reset outputs; legal range 1..8.
- `HOLD_CYCLES`, 16: minimum assertion stretch in clocks; must be ≥1.
- `LOCK_FILTER`, 4: consecutive locked samples required before release starts; must be ≥1.
- `STAGE_GAP`, 8: clocks between successive stage releases; must be ≥1.

Ports:
- `clk_i`  in  1  system clock.
- `rst_n_i`  in  1  reset, driven by `reset_sync` `synced_rst_o` (LOW polarity instance). One clock; reset is asynchronous and active-low.
- `pll_locked_i`  in  1  PLL lock, already synchronous to `clk_i`.
- `sw_rst_req_i`  in  1  software reset request; level-sampled every edge.
- `stage_rst_n_o`  out  NUM_STAGES  per-stage reset, active-low, registered.
- `all_released_o`  out  1  high when every stage is released.
- `busy_o`  out  1  high while sequencing or holding reset.

## Operation
- Reset values (`rst_n_i` low, asynchronous):
  - state ASSERT, all counters 0.
  - `stage_rst_n_o` = all 0, `all_released_o` = 0, `busy_o` = 1.
- FSM states: ASSERT, WAIT_LOCK, RELEASE, RUN.
- ASSERT:
  - hold counter increments each edge.
  - on the `HOLD_CYCLES`-th edge, go to WAIT_LOCK.
- WAIT_LOCK:
  - lock counter increments on each edge with `pll_locked_i`=1 and clears to 0 on any edge with it 0.
  - on the edge where the count reaches `LOCK_FILTER`, go to RELEASE and drive `stage_rst_n_o[0]` to 1 on that same edge.
- RELEASE:
  - gap counter runs.
  - every `STAGE_GAP` edges the next index is released; released bits stay 1.
  - on the edge releasing index `NUM_STAGES-1`, go to RUN and set `all_released_o`=1, `busy_o`=0.
- With `NUM_STAGES`=1, the single release goes directly to RUN.
- Abort condition: `pll_locked_i`=0 or `sw_rst_req_i`=1 sampled in WAIT_LOCK (request only), RELEASE or RUN.
  - next state is ASSERT.
  - all `stage_rst_n_o` bits go 0 simultaneously on that edge (no reverse ordering).
  - `all_released_o`=0, `busy_o`=1, and all counters clear.
- In ASSERT, `sw_rst_req_i`=1 restarts the hold counter at 0, extending the stretch. Lock state is ignored in ASSERT.
- Lock loss in WAIT_LOCK only clears the filter; it does not return to ASSERT.
- Lock loss and a software request on the same edge produce one identical abort.
- Counter width is `$clog2(max(HOLD_CYCLES, LOCK_FILTER, STAGE_GAP)+1)`. Counters saturate and never wrap.

## Timing
- Edge 1 is the first posedge after `rst_n_i` rises with `pll_locked_i` held high.
  - stage 0 releases at edge `HOLD_CYCLES+LOCK_FILTER`; defaults give edge 20.
  - stage k releases at edge `HOLD_CYCLES+LOCK_FILTER+k*STAGE_GAP`; defaults give 28 and 36.
  - `all_released_o` rises with the last stage; defaults give edge 36.
- Abort latency is 1 edge: input sampled at edge N, outputs low after edge N.
- `rst_n_i` falling asserts all outputs combinationally through async clear, with zero clock latency.
- All outputs are flop outputs; there are no combinational input-to-output paths except the async clear.

## Structure
- Shared package `reset_seq_pkg`:
  - `reset_seq_state_t` enum {ST_ASSERT, ST_WAIT_LOCK, ST_RELEASE, ST_RUN}.
  - counter-width helper function.
  - default parameter constants.
- Single module; no sub-module needed. The lock filter stays inline as one saturating counter.
- `reset_sync` is instantiated by the integrator upstream, not inside this block.

## Test plan
- Defaults, lock high from start, `rst_n_i` rises:
  - `stage_rst_n_o` goes 001 at edge 20, 011 at 28, 111 at 36.
  - `all_released_o` goes 1 at 36.
- Lock toggles 1,1,0,1,1,1,1 in WAIT_LOCK: filter restarts, and stage 0 releases 4 edges after the last 0 sample.
- `pll_locked_i` drops at edge 30 (stage 1 released): outputs are 000 after edge 30, and the sequence replays with stage 0 at edge 30+20.
- `sw_rst_req_i` pulsed 1 cycle in RUN: outputs 000 next edge, full sequence replays. Repeated pulses during ASSERT extend the hold.
- `rst_n_i` driven low mid-RELEASE between edges: outputs 000 immediately, no clock needed, and the sequence restarts from edge 1 on release.
- `NUM_STAGES`=1, `HOLD_CYCLES`=1, `LOCK_FILTER`=1: `stage_rst_n_o`=1 and `all_released_o`=1 at edge 2.
